// File: rtl/target_generator.sv
// Food-target generator for the snake game: holds the live target, counts hits,
// and draws a fresh in-range coordinate from two free-running LFSRs after each hit.
module target_generator #(
  parameter logic [7:0] MaxX     = 8'd159,
  parameter logic [6:0] MaxY     = 7'd119,
  parameter logic [7:0] InitX    = 8'd60,
  parameter logic [6:0] InitY    = 7'd50,
  parameter logic [3:0] WinScore = 4'd10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MSM_State,
  input  logic        REACHED_TARGET,
  output logic [14:0] TARGET_ADDR,
  output logic        TARGET_VALID,
  output logic [3:0]  SCORE,
  output logic        WIN
);

  typedef enum logic [1:0] {IDLE, HOLD, SEARCH, DONE} state_t;

  localparam logic [7:0] LfsrXSeed = 8'hB5;
  localparam logic [6:0] LfsrYSeed = 7'h4A;

  state_t      state_reg, state_next;
  logic [7:0]  lfsr_x_reg;
  logic [6:0]  lfsr_y_reg;
  logic        reach_d_reg;
  logic [14:0] addr_reg, addr_next;
  logic [3:0]  score_reg, score_next;
  logic        win_reg, win_next;
  logic        valid_reg, valid_next;

  logic        hit;
  logic        in_game;
  logic [14:0] cand;
  logic        cand_ok;

  assign hit     = REACHED_TARGET & ~reach_d_reg;
  assign in_game = (MSM_State == 2'b01);
  assign cand    = {lfsr_x_reg, lfsr_y_reg};
  // A candidate equal to the current target would look like no change on screen.
  assign cand_ok = (lfsr_x_reg <= MaxX) && (lfsr_y_reg <= MaxY) && (cand != addr_reg);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    score_next = score_reg;
    win_next   = win_reg;
    case (state_reg)
      IDLE: begin
        if (in_game) state_next = HOLD;
      end
      HOLD: begin
        if (!in_game) begin
          state_next = IDLE;
        end else if (hit) begin
          score_next = score_reg + 4'd1;
          if (score_reg + 4'd1 == WinScore) begin
            state_next = DONE;
            win_next   = 1'b1;
          end else begin
            state_next = SEARCH;
          end
        end
      end
      SEARCH: begin
        // Leaving GAME abandons the search and keeps the old target.
        if (!in_game) begin
          state_next = IDLE;
        end else if (cand_ok) begin
          addr_next  = cand;
          state_next = HOLD;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    valid_next = (state_next == HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      lfsr_x_reg  <= LfsrXSeed;
      lfsr_y_reg  <= LfsrYSeed;
      reach_d_reg <= 1'b0;
      addr_reg    <= {InitX, InitY};
      score_reg   <= 4'd0;
      win_reg     <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      // Maximal-length taps; both registers free-run so any nonzero seed never reaches zero.
      lfsr_x_reg  <= {lfsr_x_reg[6:0], lfsr_x_reg[7] ^ lfsr_x_reg[5] ^ lfsr_x_reg[4] ^ lfsr_x_reg[3]};
      lfsr_y_reg  <= {lfsr_y_reg[5:0], lfsr_y_reg[6] ^ lfsr_y_reg[5]};
      reach_d_reg <= REACHED_TARGET;
      addr_reg    <= addr_next;
      score_reg   <= score_next;
      win_reg     <= win_next;
      valid_reg   <= valid_next;
    end
  end

  assign TARGET_ADDR  = addr_reg;
  assign TARGET_VALID = valid_reg;
  assign SCORE        = score_reg;
  assign WIN          = win_reg;

endmodule

// File: tb/tb_target_generator.sv
// Directed bench for target_generator: reset, edge-only hits, search latency and value,
// win handling, GAME-exit priority, mid-search reset, and a multi-game stress run.
module tb_target_generator;

  logic        CLK;
  logic        RESET;
  logic [1:0]  MSM_State;
  logic        REACHED_TARGET;
  logic [14:0] TARGET_ADDR;
  logic        TARGET_VALID;
  logic [3:0]  SCORE;
  logic        WIN;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [14:0] InitAddr = 15'h1E32;

  // Reference LFSRs built from the documented seeds and feedback equations.
  logic [7:0] mx;
  logic [6:0] my;

  target_generator dut (
    .CLK(CLK),
    .RESET(RESET),
    .MSM_State(MSM_State),
    .REACHED_TARGET(REACHED_TARGET),
    .TARGET_ADDR(TARGET_ADDR),
    .TARGET_VALID(TARGET_VALID),
    .SCORE(SCORE),
    .WIN(WIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RESET) begin
      mx <= 8'hB5;
      my <= 7'h4A;
    end else begin
      mx <= {mx[6:0], mx[7] ^ mx[5] ^ mx[4] ^ mx[3]};
      my <= {my[5:0], my[6] ^ my[5]};
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic start_game();
    RESET = 1'b1;
    MSM_State = 2'b00;
    REACHED_TARGET = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    MSM_State = 2'b01;
    tick();
  endtask

  // Called just after the hit edge; follows the reference LFSRs to the first acceptable candidate.
  task automatic wait_accept(input logic [14:0] old, output logic [14:0] exp, output int lat);
    logic found;
    found = 1'b0;
    lat = -1;
    exp = old;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (mx <= 8'd159 && my <= 7'd119 && {mx, my} != old) begin
        exp = {mx, my};
        lat = i + 1;
        found = 1'b1;
      end
      tick();
    end
  endtask

  task automatic do_hit(input logic [14:0] old, input logic [3:0] exp_score, output logic [14:0] new_addr);
    logic [14:0] exp;
    int lat;
    REACHED_TARGET = 1'b1;
    tick();
    REACHED_TARGET = 1'b0;
    n_vec++;
    if (SCORE !== exp_score) begin
      n_err++;
      $display("FAIL hit_score got=%0d want=%0d", SCORE, exp_score);
    end
    n_vec++;
    if (TARGET_VALID !== 1'b0 || TARGET_ADDR !== old) begin
      n_err++;
      $display("FAIL hit_search_entry valid=%b addr=%h want valid=0 addr=%h", TARGET_VALID, TARGET_ADDR, old);
    end
    wait_accept(old, exp, lat);
    n_vec++;
    if (lat < 1) begin
      n_err++;
      $display("FAIL search_timeout latency=%0d want>=1", lat);
    end
    n_vec++;
    if (TARGET_ADDR !== exp || TARGET_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL new_target addr=%h valid=%b want addr=%h valid=1", TARGET_ADDR, TARGET_VALID, exp);
    end
    n_vec++;
    if (TARGET_ADDR[14:7] > 8'd159 || TARGET_ADDR[6:0] > 7'd119 || TARGET_ADDR == old) begin
      n_err++;
      $display("FAIL target_range addr=%h prev=%h want X<=159 Y<=119 and changed", TARGET_ADDR, old);
    end
    new_addr = TARGET_ADDR;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    MSM_State = 2'b00;
    REACHED_TARGET = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    n_vec++;
    if (TARGET_ADDR !== InitAddr || TARGET_VALID !== 1'b0 || SCORE !== 4'd0 || WIN !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state addr=%h valid=%b score=%0d win=%b want 1e32/0/0/0", TARGET_ADDR, TARGET_VALID, SCORE, WIN);
    end
    tick();
    n_vec++;
    if (TARGET_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL idle_valid got=%b want=0", TARGET_VALID);
    end
    MSM_State = 2'b01;
    tick();
    n_vec++;
    if (TARGET_VALID !== 1'b1 || TARGET_ADDR !== InitAddr || SCORE !== 4'd0 || WIN !== 1'b0) begin
      n_err++;
      $display("FAIL enter_hold valid=%b addr=%h score=%0d win=%b want 1/1e32/0/0", TARGET_VALID, TARGET_ADDR, SCORE, WIN);
    end
    $display("test_reset done: addr=%h valid=%b", TARGET_ADDR, TARGET_VALID);
  endtask

  task automatic test_hold_level();
    logic [14:0] exp;
    int lat;
    start_game();
    REACHED_TARGET = 1'b1;
    tick();
    n_vec++;
    if (SCORE !== 4'd1 || TARGET_VALID !== 1'b0 || TARGET_ADDR !== InitAddr) begin
      n_err++;
      $display("FAIL level_edge score=%0d valid=%b addr=%h want 1/0/1e32", SCORE, TARGET_VALID, TARGET_ADDR);
    end
    wait_accept(InitAddr, exp, lat);
    n_vec++;
    if (lat < 1 || TARGET_ADDR !== exp || TARGET_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL level_new_target addr=%h valid=%b lat=%0d want addr=%h valid=1", TARGET_ADDR, TARGET_VALID, lat, exp);
    end
    for (int i = 0; i < 20 - 1 - lat; i++) tick();
    n_vec++;
    if (SCORE !== 4'd1) begin
      n_err++;
      $display("FAIL level_once score=%0d want=1", SCORE);
    end
    REACHED_TARGET = 1'b0;
    tick();
    $display("test_hold_level done: new addr=%h latency=%0d score=%0d", TARGET_ADDR, lat, SCORE);
  endtask

  task automatic test_win();
    logic [14:0] prev, nxt;
    start_game();
    prev = InitAddr;
    for (int k = 1; k <= 9; k++) begin
      do_hit(prev, 4'(k), nxt);
      prev = nxt;
    end
    n_vec++;
    if (WIN !== 1'b0) begin
      n_err++;
      $display("FAIL win_early got=%b want=0", WIN);
    end
    REACHED_TARGET = 1'b1;
    tick();
    REACHED_TARGET = 1'b0;
    n_vec++;
    if (SCORE !== 4'd10 || WIN !== 1'b1 || TARGET_VALID !== 1'b0 || TARGET_ADDR !== prev) begin
      n_err++;
      $display("FAIL win score=%0d win=%b valid=%b addr=%h want 10/1/0/%h", SCORE, WIN, TARGET_VALID, TARGET_ADDR, prev);
    end
    tick();
    REACHED_TARGET = 1'b1;
    tick();
    REACHED_TARGET = 1'b0;
    tick();
    n_vec++;
    if (SCORE !== 4'd10 || WIN !== 1'b1) begin
      n_err++;
      $display("FAIL after_win score=%0d win=%b want 10/1", SCORE, WIN);
    end
    MSM_State = 2'b00;
    tick();
    MSM_State = 2'b01;
    tick();
    tick();
    n_vec++;
    if (TARGET_VALID !== 1'b0 || WIN !== 1'b1 || TARGET_ADDR !== prev) begin
      n_err++;
      $display("FAIL done_sticky valid=%b win=%b addr=%h want 0/1/%h", TARGET_VALID, WIN, TARGET_ADDR, prev);
    end
    $display("test_win done: score=%0d win=%b", SCORE, WIN);
  endtask

  task automatic test_abort_search();
    start_game();
    REACHED_TARGET = 1'b1;
    tick();
    REACHED_TARGET = 1'b0;
    MSM_State = 2'b10;
    tick();
    n_vec++;
    if (TARGET_VALID !== 1'b0 || TARGET_ADDR !== InitAddr || SCORE !== 4'd1) begin
      n_err++;
      $display("FAIL abort valid=%b addr=%h score=%0d want 0/1e32/1", TARGET_VALID, TARGET_ADDR, SCORE);
    end
    tick();
    tick();
    MSM_State = 2'b01;
    tick();
    n_vec++;
    if (TARGET_VALID !== 1'b1 || TARGET_ADDR !== InitAddr || SCORE !== 4'd1) begin
      n_err++;
      $display("FAIL abort_resume valid=%b addr=%h score=%0d want 1/1e32/1", TARGET_VALID, TARGET_ADDR, SCORE);
    end
    $display("test_abort_search done: addr=%h score=%0d", TARGET_ADDR, SCORE);
  endtask

  task automatic test_coincident();
    start_game();
    REACHED_TARGET = 1'b1;
    MSM_State = 2'b00;
    tick();
    n_vec++;
    if (SCORE !== 4'd0 || TARGET_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL coincident score=%0d valid=%b want 0/0", SCORE, TARGET_VALID);
    end
    REACHED_TARGET = 1'b0;
    MSM_State = 2'b01;
    tick();
    n_vec++;
    if (TARGET_VALID !== 1'b1 || TARGET_ADDR !== InitAddr || SCORE !== 4'd0) begin
      n_err++;
      $display("FAIL coincident_resume valid=%b addr=%h score=%0d want 1/1e32/0", TARGET_VALID, TARGET_ADDR, SCORE);
    end
    $display("test_coincident done: score=%0d", SCORE);
  endtask

  task automatic test_reset_mid_search();
    start_game();
    REACHED_TARGET = 1'b1;
    tick();
    REACHED_TARGET = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_vec++;
    if (TARGET_ADDR !== InitAddr || SCORE !== 4'd0 || TARGET_VALID !== 1'b0 || WIN !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_search addr=%h score=%0d valid=%b win=%b want 1e32/0/0/0", TARGET_ADDR, SCORE, TARGET_VALID, WIN);
    end
    $display("test_reset_mid_search done: addr=%h", TARGET_ADDR);
  endtask

  task automatic test_stress();
    logic [14:0] prev, nxt;
    int hits = 0;
    int games = 0;
    int d;
    while (hits < 5000) begin
      start_game();
      prev = InitAddr;
      for (int k = 1; k <= 9 && hits < 5000; k++) begin
        d = $urandom_range(0, 2);
        repeat (d) tick();
        do_hit(prev, 4'(k), nxt);
        prev = nxt;
        hits++;
      end
      games++;
      if (games % 4 == 0) begin
        REACHED_TARGET = 1'b1;
        tick();
        REACHED_TARGET = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_vec++;
        if (TARGET_ADDR !== InitAddr || SCORE !== 4'd0) begin
          n_err++;
          $display("FAIL stress_reset addr=%h score=%0d want 1e32/0", TARGET_ADDR, SCORE);
        end
      end
    end
    $display("test_stress done: %0d hits over %0d games", hits, games);
  endtask

  initial begin
    RESET = 1'b1;
    MSM_State = 2'b00;
    REACHED_TARGET = 1'b0;
    test_reset();
    test_hold_level();
    test_win();
    test_abort_search();
    test_coincident();
    test_reset_mid_search();
    test_stress();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
